// File: rtl/status_cond_unit.sv
// NZCV status register with condition evaluation for the ID stage.
// Tracks in-flight flag setters so ID stalls, or forwards, instead of reading stale flags.
module status_cond_unit #(
    parameter bit FORWARD     = 1'b0,
    parameter int MAX_PENDING = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       flush,
    input  logic       exe_valid,
    input  logic       s_exe,
    input  logic [3:0] alu_status,
    input  logic       id_valid,
    input  logic       s_id,
    input  logic [3:0] cond_id,
    output logic [3:0] status_q,
    output logic       carry_out,
    output logic       cond_pass,
    output logic       hazard
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    status_d;
    logic          commit, issue;
    logic          cond_dep, fwd_ok, full_stall;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        unique case (c)
            4'h0: r = z;
            4'h1: r = ~z;
            4'h2: r = cy;
            4'h3: r = ~cy;
            4'h4: r = n;
            4'h5: r = ~n;
            4'h6: r = v;
            4'h7: r = ~v;
            4'h8: r = cy & ~z;
            4'h9: r = ~cy | z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = ~z & (n == v);
            4'hD: r = z | (n != v);
            4'hE: r = 1'b1;
            4'hF: r = 1'b0;
        endcase
        return r;
    endfunction

    assign commit     = exe_valid & s_exe & ~freeze;
    assign cond_dep   = id_valid & (cond_id != 4'hE) & (cnt_q != '0);
    assign fwd_ok     = FORWARD & (cnt_q == CNT_ONE) & commit;
    assign full_stall = id_valid & s_id & (cnt_q == CNT_MAX) & ~commit;
    assign hazard     = (cond_dep & ~fwd_ok) | full_stall;
    assign issue      = id_valid & s_id & ~hazard & ~freeze & ~flush;

    assign cond_pass  = cond_eval(cond_id, fwd_ok ? alu_status : status_q);
    assign carry_out  = status_q[1];

    always_comb begin
        status_d = status_q;
        cnt_d    = cnt_q;
        if (commit) status_d = alu_status;
        // A flush only squashes younger ops; the committing EXE op is older
        if (flush & ~freeze) begin
            cnt_d = '0;
        end else if (issue & commit) begin
            cnt_d = cnt_q;
        end else if (issue) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (commit && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q <= 4'b0000;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed bench for status_cond_unit, two instances (no forwarding / forwarding).
// A flag-level model is compared every cycle; literal checks pin the model.
module tb_status_cond_unit;

    logic       clk = 1'b0;
    logic       rst, freeze, flush, exe_valid, s_exe, id_valid, s_id;
    logic [3:0] alu_status, cond_id;
    logic [3:0] st0, st1;
    logic       co0, co1, cp0, cp1, hz0, hz1;

    int errs = 0;
    int checks = 0;
    bit chk = 1'b0;

    int       mcnt[2];
    logic [3:0] mst[2];

    always #5 clk = ~clk;

    status_cond_unit #(.FORWARD(1'b0), .MAX_PENDING(2)) u0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .s_exe(s_exe), .alu_status(alu_status),
        .id_valid(id_valid), .s_id(s_id), .cond_id(cond_id),
        .status_q(st0), .carry_out(co0), .cond_pass(cp0), .hazard(hz0));

    status_cond_unit #(.FORWARD(1'b1), .MAX_PENDING(2)) u1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .s_exe(s_exe), .alu_status(alu_status),
        .id_valid(id_valid), .s_id(s_id), .cond_id(cond_id),
        .status_q(st1), .carry_out(co1), .cond_pass(cp1), .hazard(hz1));

    // Condition semantics written from the flag meanings
    function automatic bit mcond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit mcommit();
        return exe_valid && s_exe && !freeze;
    endfunction

    function automatic bit mfwd(input int k);
        return (k == 1) && mcnt[k] == 1 && mcommit();
    endfunction

    function automatic bit mhz(input int k);
        bit dep, full;
        dep  = id_valid && cond_id != 4'hE && mcnt[k] != 0 && !mfwd(k);
        full = id_valid && s_id && mcnt[k] == 2 && !mcommit();
        return dep || full;
    endfunction

    function automatic bit mpass(input int k);
        return mcond(cond_id, mfwd(k) ? alu_status : mst[k]);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mst[k]  = 4'b0000;
                mcnt[k] = 0;
            end else begin
                bit c, is;
                c  = mcommit();
                is = id_valid && s_id && !mhz(k) && !freeze && !flush;
                if (c) mst[k] = alu_status;
                if (flush && !freeze) mcnt[k] = 0;
                else if (is && c) mcnt[k] = mcnt[k];
                else if (is) mcnt[k] = mcnt[k] + 1;
                else if (c && mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
                if (mcnt[k] > 2) begin
                    errs++;
                    $display("FAIL model_cnt inst%0d got %0d max 2", k, mcnt[k]);
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got %h exp %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("m0_status", st0, mst[0]);
            cmp("m0_carry", {3'b0, co0}, {3'b0, mst[0][1]});
            cmp("m0_pass", {3'b0, cp0}, {3'b0, mpass(0)});
            cmp("m0_hazard", {3'b0, hz0}, {3'b0, mhz(0)});
            cmp("m1_status", st1, mst[1]);
            cmp("m1_carry", {3'b0, co1}, {3'b0, mst[1][1]});
            cmp("m1_pass", {3'b0, cp1}, {3'b0, mpass(1)});
            cmp("m1_hazard", {3'b0, hz1}, {3'b0, mhz(1)});
        end
    end

    task automatic cyc(input logic ev, input logic se, input logic [3:0] alu,
                       input logic iv, input logic si, input logic [3:0] cd,
                       input logic fl, input logic fr);
        @(posedge clk);
        #1;
        exe_valid = ev; s_exe = se; alu_status = alu;
        id_valid = iv; s_id = si; cond_id = cd;
        flush = fl; freeze = fr;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [3:0] act, input logic [3:0] exp);
        cmp(nm, act, exp);
    endtask

    localparam logic [3:0] SWEEP[4] = '{4'b1001, 4'b0011, 4'b1010, 4'b0101};

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; exe_valid = 1'b0; s_exe = 1'b0;
        id_valid = 1'b0; s_id = 1'b0; alu_status = 4'h0; cond_id = 4'hE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk = 1'b1;

        // reset state
        cyc(0, 0, 4'h0, 1, 0, 4'hE, 0, 0);
        lit("rst_status", st0, 4'b0000);
        lit("rst_carry", {3'b0, co0}, 4'h0);
        lit("rst_al", {3'b0, cp0}, 4'h1);
        lit("rst_hz", {3'b0, hz0}, 4'h0);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("rst_eq", {3'b0, cp0}, 4'h0);
        cyc(0, 0, 4'h0, 1, 0, 4'hF, 0, 0);
        lit("rst_nv", {3'b0, cp0}, 4'h0);

        // commit Z,C
        cyc(1, 1, 4'b0110, 0, 0, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("c_status", st0, 4'b0110);
        lit("c_carry", {3'b0, co0}, 4'h1);
        lit("c_eq", {3'b0, cp0}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'h1, 0, 0);
        lit("c_ne", {3'b0, cp0}, 4'h0);
        cyc(0, 0, 4'h0, 1, 0, 4'h8, 0, 0);
        lit("c_hi", {3'b0, cp0}, 4'h0);
        cyc(0, 0, 4'h0, 1, 0, 4'h9, 0, 0);
        lit("c_ls", {3'b0, cp0}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'hA, 0, 0);
        lit("c_ge", {3'b0, cp0}, 4'h1);

        // issue, dependent NE, then commit 1000
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 4'h1, 0, 0);
        lit("dep_hz0", {3'b0, hz0}, 4'h1);
        lit("dep_hz1", {3'b0, hz1}, 4'h1);
        cyc(1, 1, 4'b1000, 1, 0, 4'h1, 0, 0);
        lit("cmt_hz0", {3'b0, hz0}, 4'h1);
        lit("cmt_hz1_fwd", {3'b0, hz1}, 4'h0);
        lit("cmt_pass1_fwd", {3'b0, cp1}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'h1, 0, 0);
        lit("after_hz0", {3'b0, hz0}, 4'h0);
        lit("after_ne", {3'b0, cp0}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'h4, 0, 0);
        lit("after_mi", {3'b0, cp0}, 4'h1);

        // forwarded Z on EQ
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        cyc(1, 1, 4'b0100, 1, 0, 4'h0, 0, 0);
        lit("fwd_hz1", {3'b0, hz1}, 4'h0);
        lit("fwd_eq1", {3'b0, cp1}, 4'h1);
        lit("nofwd_hz0", {3'b0, hz0}, 4'h1);
        cyc(0, 0, 4'h0, 0, 0, 4'hE, 0, 0);

        // fill to MAX, full stall, then flush with same-cycle commit
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        lit("full_hz0", {3'b0, hz0}, 4'h1);
        lit("full_hz1", {3'b0, hz1}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("full_dep", {3'b0, hz0}, 4'h1);
        cyc(1, 1, 4'b0001, 0, 0, 4'hE, 1, 0);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("fl_status", st0, 4'b0001);
        lit("fl_hz", {3'b0, hz0}, 4'h0);
        lit("fl_eq", {3'b0, cp0}, 4'h0);

        // refill, then freeze holds everything
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        cyc(1, 1, 4'b1111, 1, 1, 4'hE, 1, 1);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("frz_status", st0, 4'b0001);
        lit("frz_hz", {3'b0, hz0}, 4'h1);
        cyc(0, 0, 4'h0, 1, 1, 4'hE, 0, 0);
        lit("frz_full", {3'b0, hz0}, 4'h1);

        // reset mid-stream
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 1'b1; s_id = 1'b0; cond_id = 4'h0;
        @(negedge clk);
        lit("rst2_status", st0, 4'b0000);
        lit("rst2_hz", {3'b0, hz0}, 4'h0);

        // condition sweep over several flag patterns
        foreach (SWEEP[i]) begin
            cyc(1, 1, SWEEP[i], 0, 0, 4'hE, 0, 0);
            for (int c = 0; c < 16; c++) cyc(0, 0, 4'h0, 1, 0, 4'(c), 0, 0);
        end
        cyc(0, 0, 4'h0, 1, 0, 4'hB, 0, 0);
        lit("sw_lt", {3'b0, cp0}, 4'h1);
        cyc(0, 0, 4'h0, 1, 0, 4'hC, 0, 0);
        lit("sw_gt", {3'b0, cp0}, 4'h0);

        // unissued commit at zero count stays zero
        cyc(1, 1, 4'b0100, 1, 0, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        lit("zc_hz", {3'b0, hz0}, 4'h0);
        lit("zc_eq", {3'b0, cp0}, 4'h1);

        chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Holds the architectural NZCV status register directly downstream of the ALU, capturing its 4-bit status output when an S-flagged instruction commits in EXE.
- Feeds the stored carry back to the ALU carry-in.
- Evaluates the 4-bit condition field of the instruction in ID against current status, producing cond_pass.
- Tracks in-flight flag-setting instructions so ID stalls (or forwards) instead of reading stale flags.

Parameters:
- FORWARD, 0: 1 = when exactly one S instruction is pending and it commits this cycle, evaluate cond against alu_status instead of stalling.
- MAX_PENDING, 2: max S instructions tracked between ID issue and EXE commit; counter width = clog2(MAX_PENDING+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- freeze  in  1  global pipeline stall; all state holds
- flush  in  1  squash younger instructions (branch taken in EXE)
- exe_valid  in  1  valid instruction in EXE
- s_exe  in  1  S bit of the EXE instruction
- alu_status  in  4  ALU status {N,Z,C,V} (bit3..bit0)
- id_valid  in  1  valid instruction in ID
- s_id  in  1  S bit of the ID instruction
- cond_id  in  4  condition field of the ID instruction
- status_q  out  4  registered {N,Z,C,V}
- carry_out  out  1  status_q[1], to ALU carry-in
- cond_pass  out  1  ID instruction's condition holds
- hazard  out  1  ID must stall this cycle

Behaviour:
- Reset (rst==0 at posedge): status_q=4'b0000, pending_cnt=0. carry_out=0; cond_pass and hazard follow the combinational rules with those values.
- commit = exe_valid & s_exe & ~freeze. On commit: status_q <= alu_status at the next edge (1-cycle latency). Without commit, status_q holds.
- issue = id_valid & s_id & ~hazard & ~freeze & ~flush.
- pending_cnt update, in priority order:
  - flush & ~freeze: pending_cnt <= 0. A same-cycle commit still updates status_q, because the EXE instruction is older.
  - issue & commit: unchanged.
  - issue only: +1.
  - commit only (pending_cnt>0): -1.
  - commit only at pending_cnt==0 (unissued S op, e.g. after reset): stays 0.
- freeze=1: status_q and pending_cnt hold; outputs are still evaluated combinationally.
- Condition table, flags from src (status_q, or alu_status when forwarding):
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
- Combinational hazard:
  - cond_dep = id_valid & (cond_id!=1110) & (pending_cnt!=0).
  - fwd_ok = FORWARD & (pending_cnt==1) & commit.
  - full_stall = id_valid & s_id & (pending_cnt==MAX_PENDING) & ~commit.
  - hazard = (cond_dep & ~fwd_ok) | full_stall.
- cond_pass = table(cond_id, fwd_ok ? alu_status : status_q). cond_pass is don't-care while hazard=1, but must be deterministic (no X).
- id_valid=0 forces hazard=0. cond_pass is still table-evaluated.
- Counter never exceeds MAX_PENDING and never underflows; violating either is a verification error.

Test Plan:
- Reset then cond_id=1110, id_valid=1 -> status_q=0000, carry_out=0, cond_pass=1, hazard=0. cond_id=0000 -> cond_pass=0. cond_id=1111 -> cond_pass=0.
- Commit with alu_status=4'b0110 (Z,C), freeze=0 -> next cycle status_q=0110, carry_out=1. EQ->1, NE->0, HI->0, LS->1, GE->1.
- Issue S op (id_valid=1, s_id=1), next cycle ID cond_id=0001, no commit, FORWARD=0 -> pending_cnt=1, hazard=1. Commit alu_status=1000 that cycle -> hazard=1 that cycle; next cycle pending_cnt=0, hazard=0, cond_pass=1, and MI->1.
- FORWARD=1, same sequence with alu_status=0100 committing -> hazard=0 in the commit cycle, EQ cond_pass=1 from forwarded Z.
- pending_cnt=2 (MAX), flush=1 and commit of alu_status=0001 in the same cycle -> next cycle pending_cnt=0, status_q=0001. With freeze=1 instead of flush -> pending_cnt=2 and status_q unchanged.
- pending_cnt=2, id_valid=1, s_id=1, cond_id=1110, no commit -> hazard=1, counter stays 2. rst=0 mid-stream -> next cycle status_q=0000, pending_cnt=0.
